// File: rtl/upg_loader_pkg.sv
// Shared types and constants for the UART program loader.
package upg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TGT    = 3'd1,
    ST_CNT_LO = 3'd2,
    ST_CNT_HI = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } upg_state_e;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic        TGT_IMEM          = 1'b0;
  localparam logic        TGT_DMEM          = 1'b1;
  localparam logic [15:0] MAX_WORDS         = 16'd16384;

  // Running frame checksum: XOR of every byte between SYNC and CSUM.
  function automatic logic [7:0] csum_step(input logic [7:0] csum, input logic [7:0] data);
    return csum ^ data;
  endfunction

endpackage

// File: rtl/upg_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and publishes each completed word.
module upg_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt_r;
  logic [23:0] shift_r;
  logic        word_valid_r;
  logic [31:0] word_r;

  // Flags the incoming byte that completes the current word.
  always_comb begin
    last_byte = 1'b0;
    if (byte_valid && (byte_cnt_r == 2'd3)) begin
      last_byte = 1'b1;
    end else begin
      last_byte = 1'b0;
    end
  end

  // Shift bytes in LSB first; the output word only changes when a word completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt_r   <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
      word_r       <= 32'd0;
    end else if (clear) begin
      byte_cnt_r   <= 2'd0;
      shift_r      <= 24'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= last_byte;
      if (byte_valid) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        shift_r    <= {byte_in, shift_r[23:8]};
        if (byte_cnt_r == 2'd3) begin
          word_r <= {byte_in, shift_r};
        end
      end
    end
  end

  assign word_valid = word_valid_r;
  assign word       = word_r;

endmodule

// File: rtl/upg_loader.sv
// UART program loader: parses framed load commands and drives the upg_* programming port.
module upg_loader
  import upg_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  upg_state_e       state_r;
  upg_state_e       state_next_s;
  logic             target_r;
  logic [15:0]      cnt_r;
  logic [13:0]      index_r;
  logic [7:0]       csum_r;
  logic [TMO_W-1:0] tmo_r;
  logic [14:0]      adr_r;
  logic             rst_r;
  logic             done_r;
  logic             err_r;
  logic             rst_next_s;
  logic             done_next_s;
  logic             err_next_s;
  logic             in_frame_s;
  logic             frame_start_s;
  logic             tmo_expired_s;
  logic             data_byte_s;
  logic             last_byte_s;
  logic             last_word_s;
  logic [15:0]      cnt_full_s;

  assign in_frame_s    = state_r inside {ST_TGT, ST_CNT_LO, ST_CNT_HI, ST_DATA, ST_CSUM};
  assign frame_start_s = rx_valid && (rx_byte == SYNC_BYTE) &&
                         (state_r inside {ST_IDLE, ST_DONE, ST_ERR});
  assign tmo_expired_s = in_frame_s && !rx_valid && (tmo_r == TMO_LAST);
  assign data_byte_s   = rx_valid && (state_r == ST_DATA);
  assign cnt_full_s    = {rx_byte, cnt_r[7:0]};
  assign last_word_s   = last_byte_s && ({2'b00, index_r} == (cnt_r - 16'd1));

  upg_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (frame_start_s),
    .byte_valid (data_byte_s),
    .byte_in    (rx_byte),
    .last_byte  (last_byte_s),
    .word_valid (upg_wen_o),
    .word       (upg_dat_o)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a timeout can only fire on a cycle without a byte.
  always_comb begin
    state_next_s = state_r;
    if (tmo_expired_s) begin
      state_next_s = ST_ERR;
    end else if (rx_valid) begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (rx_byte == SYNC_BYTE) state_next_s = ST_TGT;
          else                      state_next_s = state_r;
        end
        ST_TGT: begin
          if (rx_byte[7:1] != 7'd0) state_next_s = ST_ERR;
          else                      state_next_s = ST_CNT_LO;
        end
        ST_CNT_LO: state_next_s = ST_CNT_HI;
        ST_CNT_HI: begin
          if (cnt_full_s > MAX_WORDS)   state_next_s = ST_ERR;
          else if (cnt_full_s == 16'd0) state_next_s = ST_CSUM;
          else                          state_next_s = ST_DATA;
        end
        ST_DATA: begin
          if (last_word_s) state_next_s = ST_CSUM;
          else             state_next_s = ST_DATA;
        end
        ST_CSUM: begin
          if (rx_byte == csum_r) state_next_s = ST_DONE;
          else                   state_next_s = ST_ERR;
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Status levels derived from the state being entered, so they register in step with it.
  always_comb begin
    rst_next_s  = 1'b1;
    done_next_s = 1'b0;
    err_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: rst_next_s = 1'b1;
      ST_DONE: done_next_s = 1'b1;
      ST_ERR:  err_next_s = 1'b1;
      default: rst_next_s = 1'b0;
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_r  <= 1'b1;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      rst_r  <= rst_next_s;
      done_r <= done_next_s;
      err_r  <= err_next_s;
    end
  end

  // Frame header capture, checksum accumulation and write addressing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target_r <= TGT_IMEM;
      cnt_r    <= 16'd0;
      index_r  <= 14'd0;
      csum_r   <= 8'd0;
      adr_r    <= 15'd0;
    end else if (frame_start_s) begin
      cnt_r   <= 16'd0;
      index_r <= 14'd0;
      csum_r  <= 8'd0;
    end else begin
      if (rx_valid && (state_r inside {ST_TGT, ST_CNT_LO, ST_CNT_HI, ST_DATA})) begin
        csum_r <= csum_step(csum_r, rx_byte);
      end
      if (rx_valid && (state_r == ST_TGT)) begin
        target_r <= rx_byte[0] ? TGT_DMEM : TGT_IMEM;
      end
      if (rx_valid && (state_r == ST_CNT_LO)) begin
        cnt_r[7:0] <= rx_byte;
      end
      if (rx_valid && (state_r == ST_CNT_HI)) begin
        cnt_r[15:8] <= rx_byte;
      end
      if (last_byte_s) begin
        adr_r   <= {target_r, index_r};
        index_r <= index_r + 14'd1;
      end
    end
  end

  // Inter-byte idle counter; saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_r <= '0;
    end else if (!in_frame_s || rx_valid) begin
      tmo_r <= '0;
    end else if (tmo_r != TMO_MAX) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end
  end

  assign upg_rst_o  = rst_r;
  assign upg_adr_o  = adr_r;
  assign upg_done_o = done_r;
  assign upg_err_o  = err_r;

endmodule
